// File: rtl/sig_bundle_serializer_if.sv
// Bundle-in / byte-out handshake bundle for sig_bundle_serializer.
// slave is the serializer's view, master is the producer/consumer side.
interface sig_bundle_serializer_if #(parameter int N = 3);
  logic                in_valid;
  logic                in_ready;
  logic                sig_i;
  logic [1:0]          sig_j;
  logic [0:N-1][7:0]   sig_k;
  logic [7:0]          sig_l [0:N-1];
  logic                out_valid;
  logic                out_ready;
  logic [7:0]          out_data;
  logic                out_last;

  modport slave (
    input  in_valid, sig_i, sig_j, sig_k, sig_l, out_ready,
    output in_ready, out_valid, out_data, out_last
  );

  modport master (
    output in_valid, sig_i, sig_j, sig_k, sig_l, out_ready,
    input  in_ready, out_valid, out_data, out_last
  );
endinterface

// File: rtl/sig_bundle_serializer.sv
// Captures one sig_i/j/k/l bundle per handshake and streams it as a byte frame:
// header {HDR_TAG, sig_i, sig_j}, then sig_k[0..N-1], then sig_l[0..N-1].
//
// state | meaning
// IDLE  | no frame in flight, in_ready=1
// HDR   | header byte on out_data
// KB    | sig_k[idx] on out_data
// LB    | sig_l[idx] on out_data; last index carries out_last
module sig_bundle_serializer #(
  parameter int          N       = 3,
  parameter logic [4:0]  HDR_TAG = 5'h15
) (
  input  logic                  clk,
  input  logic                  rst,
  sig_bundle_serializer_if.slave bus,
  output logic                  busy,
  output logic [15:0]           frame_cnt
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam logic [IW-1:0] IDX_LAST = IW'(N - 1);

  typedef enum logic [1:0] {IDLE, HDR, KB, LB} state_t;

  state_t            state;
  logic [IW-1:0]     idx;
  logic [0:N-1][7:0] k_q;
  logic [7:0]        l_q [0:N-1];
  logic [15:0]       cnt_q;

  logic          out_fire;
  logic          last_fire;
  logic          in_fire;
  logic [IW-1:0] idx_nx;

  assign out_fire  = bus.out_valid & bus.out_ready;
  assign last_fire = (state == LB) && (idx == IDX_LAST) && out_fire;
  // Accepting on the last-byte handshake lets frames run back-to-back.
  assign bus.in_ready = ~rst & ((state == IDLE) | last_fire);
  assign in_fire   = bus.in_valid & bus.in_ready;
  assign idx_nx    = idx + 1'b1;
  assign busy      = (state != IDLE);
  assign frame_cnt = cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      idx           <= '0;
      bus.out_valid <= 1'b0;
      bus.out_data  <= 8'h00;
      bus.out_last  <= 1'b0;
      cnt_q         <= 16'h0000;
    end else begin
      cnt_q <= cnt_q + {15'd0, last_fire};
      if (in_fire) begin
        state         <= HDR;
        idx           <= '0;
        k_q           <= bus.sig_k;
        l_q           <= bus.sig_l;
        bus.out_valid <= 1'b1;
        bus.out_data  <= {HDR_TAG, bus.sig_i, bus.sig_j};
        bus.out_last  <= 1'b0;
      end else if (out_fire) begin
        case (state)
          HDR: begin
            state        <= KB;
            idx          <= '0;
            bus.out_data <= k_q[0];
            bus.out_last <= 1'b0;
          end
          KB: begin
            if (idx == IDX_LAST) begin
              state        <= LB;
              idx          <= '0;
              bus.out_data <= l_q[0];
              bus.out_last <= (N == 1);
            end else begin
              idx          <= idx_nx;
              bus.out_data <= k_q[idx_nx];
            end
          end
          LB: begin
            if (idx == IDX_LAST) begin
              state         <= IDLE;
              bus.out_valid <= 1'b0;
              bus.out_last  <= 1'b0;
            end else begin
              idx          <= idx_nx;
              bus.out_data <= l_q[idx_nx];
              bus.out_last <= (idx_nx == IDX_LAST);
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sig_bundle_serializer.sv
// Self-checking bench: a byte-queue model of the frame format, checked every cycle.
module tb_sig_bundle_serializer;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sig_bundle_serializer_if #(.N(3)) b3();
  sig_bundle_serializer_if #(.N(1)) b1();
  logic        busy3, busy1;
  logic [15:0] fc3, fc1;

  sig_bundle_serializer #(.N(3), .HDR_TAG(5'h15)) dut3 (
    .clk(clk), .rst(rst), .bus(b3.slave), .busy(busy3), .frame_cnt(fc3));
  sig_bundle_serializer #(.N(1), .HDR_TAG(5'h15)) dut1 (
    .clk(clk), .rst(rst), .bus(b1.slave), .busy(busy1), .frame_cnt(fc1));

  typedef struct packed {
    logic            i;
    logic [1:0]      j;
    logic [0:2][7:0] k;
    logic [0:2][7:0] l;
  } bundle_t;

  int          n_tests = 0;
  int          n_fail  = 0;
  bundle_t     pend[$];
  logic [8:0]  q[$];
  logic [15:0] cnt_m;
  bit          presenting;
  bit          prev_stall;
  logic [8:0]  prev_out;
  int          pat = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit pick(input int mode);
    bit r;
    case (mode)
      0:       r = 1'b1;
      1:       r = (pat % 4 == 0) || (pat % 4 == 3);
      default: r = 1'($urandom);
    endcase
    pat++;
    return r;
  endfunction

  task automatic push_frame(input bundle_t b);
    q.push_back({1'b0, 5'h15, b.i, b.j});
    for (int x = 0; x < 3; x++) q.push_back({1'b0, b.k[x]});
    for (int x = 0; x < 3; x++) q.push_back({x == 2, b.l[x]});
  endtask

  task automatic step(input bit ordy, input bit may_present);
    logic [8:0] e;
    @(negedge clk);
    chk("frame_cnt", fc3, cnt_m);
    chk("out_valid", b3.out_valid, q.size() != 0);
    chk("busy", busy3, q.size() != 0);
    if (prev_stall) chk("stall_hold", {b3.out_last, b3.out_data}, prev_out);
    if (!presenting && pend.size() != 0 && may_present) begin
      b3.sig_i = pend[0].i;
      b3.sig_j = pend[0].j;
      b3.sig_k = pend[0].k;
      for (int x = 0; x < 3; x++) b3.sig_l[x] = pend[0].l[x];
      b3.in_valid = 1'b1;
      presenting  = 1'b1;
    end else if (!presenting) begin
      b3.in_valid = 1'b0;
      b3.sig_i = 1'($urandom);
      b3.sig_j = 2'($urandom);
      b3.sig_k = 24'($urandom);
      for (int x = 0; x < 3; x++) b3.sig_l[x] = 8'($urandom);
    end
    b3.out_ready = ordy;
    #1;
    chk("in_ready", b3.in_ready, (q.size() == 0) || (q.size() == 1 && ordy));
    if (b3.out_valid && ordy) begin
      if (q.size() == 0) chk("extra_byte", b3.out_valid, 1'b0);
      else begin
        e = q.pop_front();
        chk("byte", {b3.out_last, b3.out_data}, e);
        if (e[8]) cnt_m++;
      end
    end
    if (presenting && b3.in_ready) begin
      push_frame(pend.pop_front());
      presenting = 1'b0;
    end
    prev_stall = b3.out_valid && !ordy;
    prev_out   = {b3.out_last, b3.out_data};
  endtask

  task automatic drain(input int mode);
    int budget = 3000;
    while ((q.size() != 0 || pend.size() != 0 || presenting) && budget > 0) begin
      step(pick(mode), (mode < 2) ? 1'b1 : ($urandom_range(0, 3) != 0));
      budget--;
    end
    chk("drain_left", q.size() + pend.size(), 0);
  endtask

  bundle_t b_a, b_b, b_r;

  initial begin
    rst = 1'b1;
    b3.in_valid = 1'b0; b3.out_ready = 1'b0;
    b3.sig_i = 1'b0; b3.sig_j = 2'b0; b3.sig_k = '0;
    for (int x = 0; x < 3; x++) b3.sig_l[x] = 8'h00;
    b1.in_valid = 1'b0; b1.out_ready = 1'b0;
    b1.sig_i = 1'b0; b1.sig_j = 2'b0; b1.sig_k = '0; b1.sig_l[0] = 8'h00;
    cnt_m = 16'h0000; presenting = 1'b0; prev_stall = 1'b0; prev_out = '0;
    b_a = '{i: 1'b1, j: 2'b10, k: {8'h11, 8'h22, 8'h33}, l: {8'hAA, 8'hBB, 8'hCC}};
    b_b = '{i: 1'b0, j: 2'b01, k: {8'h01, 8'h02, 8'h03}, l: {8'h04, 8'h05, 8'h06}};

    // reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    chk("rst_out_valid", b3.out_valid, 1'b0);
    chk("rst_out_data", b3.out_data, 8'h00);
    chk("rst_out_last", b3.out_last, 1'b0);
    chk("rst_busy", busy3, 1'b0);
    chk("rst_frame_cnt", fc3, 16'h0000);
    chk("rst_in_ready", b3.in_ready, 1'b0);
    rst = 1'b0;

    // single frame, full throughput
    pend.push_back(b_a);
    drain(0);
    step(1'b1, 1'b0);
    chk("single_cnt", fc3, 16'd1);

    // backpressure 1,0,0,1
    pend.push_back(b_a);
    drain(1);
    step(1'b1, 1'b0);

    // back-to-back frames
    pend.push_back(b_a);
    pend.push_back(b_b);
    drain(0);
    step(1'b1, 1'b0);
    chk("b2b_cnt", fc3, 16'd4);

    // reset after byte 22
    pend.push_back(b_a);
    for (int c = 0; c < 20 && q.size() != 4; c++) step(1'b1, 1'b1);
    chk("pre_reset_q", q.size(), 4);
    @(negedge clk);
    rst = 1'b1;
    b3.in_valid = 1'b0;
    presenting = 1'b0;
    #1;
    chk("rst_mid_in_ready", b3.in_ready, 1'b0);
    @(negedge clk);
    chk("rst_mid_out_valid", b3.out_valid, 1'b0);
    chk("rst_mid_out_last", b3.out_last, 1'b0);
    chk("rst_mid_busy", busy3, 1'b0);
    chk("rst_mid_cnt", fc3, 16'h0000);
    rst = 1'b0;
    q.delete();
    cnt_m = 16'h0000;
    prev_stall = 1'b0;
    pend.push_back(b_b);
    drain(1);
    step(1'b1, 1'b0);

    // randomized bundles with random ready and random presentation gaps
    for (int n = 0; n < 40; n++) begin
      b_r.i = 1'($urandom);
      b_r.j = 2'($urandom);
      b_r.k = 24'($urandom);
      b_r.l = 24'($urandom);
      pend.push_back(b_r);
    end
    drain(2);
    step(1'b1, 1'b0);

    // counter wrap: preload 16'hFFFF while idle
    @(negedge clk);
    force dut3.cnt_q = 16'hFFFF;
    @(posedge clk);
    #1;
    release dut3.cnt_q;
    cnt_m = 16'hFFFF;
    prev_stall = 1'b0;
    pend.push_back(b_b);
    drain(0);
    step(1'b1, 1'b0);
    chk("wrap_cnt", fc3, 16'h0000);

    // N=1 instance
    @(negedge clk);
    b1.sig_i = 1'b0; b1.sig_j = 2'b00; b1.sig_k = 8'h5A; b1.sig_l[0] = 8'hA5;
    b1.in_valid = 1'b1; b1.out_ready = 1'b1;
    #1;
    chk("n1_in_ready", b1.in_ready, 1'b1);
    @(negedge clk);
    b1.in_valid = 1'b0;
    b1.sig_k = 8'hFF; b1.sig_l[0] = 8'h00; b1.sig_i = 1'b1; b1.sig_j = 2'b11;
    chk("n1_b0", {b1.out_valid, b1.out_last, b1.out_data}, {1'b1, 1'b0, 8'hA8});
    @(negedge clk);
    chk("n1_b1", {b1.out_valid, b1.out_last, b1.out_data}, {1'b1, 1'b0, 8'h5A});
    @(negedge clk);
    chk("n1_b2", {b1.out_valid, b1.out_last, b1.out_data}, {1'b1, 1'b1, 8'hA5});
    @(negedge clk);
    chk("n1_idle", b1.out_valid, 1'b0);
    chk("n1_busy", busy1, 1'b0);
    chk("n1_cnt", fc1, 16'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
